sw_debounce: RTL and testbench
==============================

SW_DEBOUNCE -- requirements
Module: sw_debounce

Interface
REQ-001 Parameter: TICK_DIV, default 100000, clocks per debounce sample tick (legal range >=1).
REQ-002 Parameter: STABLE_TICKS, default 10, consecutive matching ticks required to accept a new switch code (legal range >=1).
REQ-003 Port: clk  input  1  single system clock; all flops on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset; asserts immediately, releases synchronously to clk.
REQ-005 Port: sw_in  input  3  raw, asynchronous slide-switch code from the board pins.
REQ-006 Port: sw_out  output  3  debounced switch code; drives the downstream state machine's sw input directly.
REQ-007 Port: sw_changed  output  1  one-cycle pulse coincident with each update of sw_out.
REQ-008 Port: busy  output  1  high while a candidate code is being qualified (state CHECK).

Function
REQ-009 The block SHALL pass each sw_in bit through a 2-flop synchronizer; the second-stage vector is sw_sync, and no other logic SHALL sample sw_in.
REQ-010 The block SHALL contain a free-running tick counter, 0..TICK_DIV-1, wrapping to 0, that asserts internal tick in the cycle when the count equals TICK_DIV-1; TICK_DIV=1 gives tick every cycle.
REQ-011 Counter widths SHALL be $clog2-sized to hold TICK_DIV-1 and STABLE_TICKS-1, minimum 1 bit.
REQ-012 The control FSM SHALL have exactly two states: IDLE (sw_out stable) and CHECK (candidate under qualification).
REQ-013 IDLE: when sw_sync != sw_out, the FSM SHALL load candidate <= sw_sync, load stable_cnt <= 0, and enter CHECK on that edge.
REQ-014 IDLE: when sw_sync == sw_out, the FSM SHALL remain in IDLE with no register changes other than the tick counter.
REQ-015 CHECK: sw_sync SHALL be compared with candidate every clock, not only on tick cycles.
REQ-016 CHECK, sw_sync == sw_out: the FSM SHALL return to IDLE with no pulse and sw_out unchanged (bounce back to the old value). This rule has priority over REQ-017.
REQ-017 CHECK, sw_sync differs from both candidate and sw_out: the FSM SHALL reload candidate <= sw_sync and stable_cnt <= 0, and stay in CHECK.
REQ-018 CHECK, sw_sync == candidate, tick high, stable_cnt < STABLE_TICKS-1: the FSM SHALL increment stable_cnt.
REQ-019 CHECK, sw_sync == candidate, tick high, stable_cnt == STABLE_TICKS-1: on that edge the FSM SHALL set sw_out <= candidate, set sw_changed for one cycle, and enter IDLE.
REQ-020 CHECK, sw_sync == candidate, tick low: the FSM SHALL hold all state.
REQ-021 sw_changed SHALL never be high for two consecutive cycles, because IDLE needs at least one cycle before it can re-enter CHECK.
REQ-022 busy SHALL equal (state == CHECK), registered and glitch-free.
REQ-023 The tick counter SHALL NOT be reset or realigned by FSM transitions, so the first counted tick may arrive 1..TICK_DIV cycles after entering CHECK.

Reset
REQ-024 While reset is low, the following SHALL be held at 0: both synchronizer stages, tick counter, stable_cnt, candidate, sw_out, sw_changed, and busy; state SHALL be IDLE.
REQ-025 Reset asserted mid-CHECK SHALL abort qualification with no sw_changed pulse, and sw_out SHALL read 000 immediately.
REQ-026 After reset release, a constant nonzero sw_in SHALL be qualified as a normal change from 000.

Verification (bench parameters TICK_DIV=1, STABLE_TICKS=3 unless stated)
REQ-027 Clean step: sw_in 000->001 before edge 0 and held -> CHECK entered at edge 2; sw_out=001 and sw_changed=1 after edge 5 only; busy high after edges 2-4.
REQ-028 Bounce back: sw_in 000->100 for 3 cycles, then back to 000 -> busy pulses, sw_out stays 000, sw_changed never asserts.
REQ-029 Re-candidate: sw_in 000->001 for 2 cycles, then 011 held -> candidate reloads to 011; final sw_out=011 with exactly one sw_changed pulse.
REQ-030 Slow tick: TICK_DIV=4, STABLE_TICKS=2, sw_in 000->010 held -> sw_out=010 within 2+1+8 cycles of the change and not earlier than 2+1+5 cycles.
REQ-031 Reset mid-CHECK: sw_in=101, reset driven low while busy=1 -> sw_out=000, busy=0, no pulse; after release with sw_in=101 held, sw_out=101 after requalification.
REQ-032 Sequence to the downstream FSM: drive 001,010,011,100,101,110, each held 10 cycles -> sw_out follows each code with exactly six sw_changed pulses and no intermediate codes.

Source files
------------

// File: rtl/sw_debounce.sv
// Slide-switch debouncer: 2-flop synchronizer, free-running sample tick,
// and a two-state qualifier that only accepts a new code after it has held
// steady for STABLE_TICKS consecutive ticks.
module sw_debounce #(
  parameter int TICK_DIV     = 100000,
  parameter int STABLE_TICKS = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] sw_in,
  output logic [2:0] sw_out,
  output logic       sw_changed,
  output logic       busy
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam logic [TW-1:0] TICK_MAX   = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_TICKS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CHECK = 1'b1
  } state_t;

  logic [2:0]    sync_meta;
  logic [2:0]    sw_sync;
  logic [TW-1:0] tick_cnt;
  logic          tick;

  state_t        state;
  state_t        state_next;
  logic [2:0]    candidate;
  logic [2:0]    candidate_next;
  logic [SW-1:0] stable_cnt;
  logic [SW-1:0] stable_cnt_next;
  logic [2:0]    sw_out_next;
  logic          changed_next;

  // Two-stage synchronizer; sw_sync is the only consumer-visible copy of sw_in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_meta <= '0;
      sw_sync   <= '0;
    end else begin
      sync_meta <= sw_in;
      sw_sync   <= sync_meta;
    end
  end

  // Free-running sample tick divider, independent of the FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_MAX) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  assign tick = (tick_cnt == TICK_MAX);

  // Qualifier next-state: bounce back to sw_out wins over re-candidating.
  always_comb begin
    state_next      = state;
    candidate_next  = candidate;
    stable_cnt_next = stable_cnt;
    sw_out_next     = sw_out;
    changed_next    = 1'b0;
    case (state)
      IDLE: begin
        if (sw_sync != sw_out) begin
          candidate_next  = sw_sync;
          stable_cnt_next = '0;
          state_next      = CHECK;
        end
      end
      CHECK: begin
        if (sw_sync == sw_out) begin
          state_next = IDLE;
        end else if (sw_sync != candidate) begin
          candidate_next  = sw_sync;
          stable_cnt_next = '0;
        end else if (tick) begin
          if (stable_cnt == STABLE_MAX) begin
            sw_out_next  = candidate;
            changed_next = 1'b1;
            state_next   = IDLE;
          end else begin
            stable_cnt_next = stable_cnt + SW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Qualifier registers; busy is registered from the next state so it is glitch-free.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      candidate  <= '0;
      stable_cnt <= '0;
      sw_out     <= '0;
      sw_changed <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      candidate  <= candidate_next;
      stable_cnt <= stable_cnt_next;
      sw_out     <= sw_out_next;
      sw_changed <= changed_next;
      busy       <= (state_next == CHECK);
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce: two instances (fast tick and slow tick),
// each with a reference model pushing expected updates into a queue.
module tb_sw_debounce;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] sw_in_a, sw_in_b;
  logic [2:0] sw_out_a, sw_out_b;
  logic       sw_changed_a, sw_changed_b;
  logic       busy_a, busy_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sw_debounce #(.TICK_DIV(1), .STABLE_TICKS(3)) dut_a (
    .clk(clk), .reset(reset), .sw_in(sw_in_a),
    .sw_out(sw_out_a), .sw_changed(sw_changed_a), .busy(busy_a)
  );

  sw_debounce #(.TICK_DIV(4), .STABLE_TICKS(2)) dut_b (
    .clk(clk), .reset(reset), .sw_in(sw_in_b),
    .sw_out(sw_out_b), .sw_changed(sw_changed_b), .busy(busy_b)
  );

  task automatic check(input bit ok, input string name, input int act, input int exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference: the output moves to v once the synchronized input has been
  // constant at v (v != current output) for STABLE_TICKS ticks strictly
  // after the edge on which that constant run began.
  typedef struct {
    int         n;
    logic [2:0] run_val;
    int         ticks;
    logic [2:0] out;
    logic       busy;
  } model_t;

  function automatic model_t model_reset();
    model_t m;
    m.n = 0; m.run_val = 3'b000; m.ticks = 0; m.out = 3'b000; m.busy = 1'b0;
    return m;
  endfunction

  function automatic model_t model_step(input model_t m, input logic [2:0] v,
                                        input int td, input int st, output bit upd);
    bit tk;
    upd = 1'b0;
    tk  = ((m.n % td) == td - 1);
    if (v != m.run_val) begin
      m.run_val = v;
      m.ticks   = 0;
    end else if (tk) begin
      m.ticks++;
      if (v != m.out && m.ticks == st) begin
        upd   = 1'b1;
        m.out = v;
      end
    end
    m.busy = (v != m.out);
    m.n++;
    return m;
  endfunction

  model_t     ma, mb;
  logic [2:0] hist_a[$], hist_b[$];
  logic [2:0] expq_a[$], expq_b[$];
  int         pulses_a = 0, pulses_b = 0;
  logic       prev_chg_a = 1'b0, prev_chg_b = 1'b0;

  // Model A: the synchronized value seen on edge n is sw_in sampled on edge n-2.
  always @(posedge clk or negedge reset) begin : model_a
    bit u;
    logic [2:0] v;
    if (!reset) begin
      ma = model_reset();
      hist_a.delete();
      expq_a.delete();
    end else begin
      v = (hist_a.size() >= 2) ? hist_a[hist_a.size()-2] : 3'b000;
      hist_a.push_back(sw_in_a);
      ma = model_step(ma, v, 1, 3, u);
      if (u) expq_a.push_back(ma.out);
    end
  end

  // Model B.
  always @(posedge clk or negedge reset) begin : model_b
    bit u;
    logic [2:0] v;
    if (!reset) begin
      mb = model_reset();
      hist_b.delete();
      expq_b.delete();
    end else begin
      v = (hist_b.size() >= 2) ? hist_b[hist_b.size()-2] : 3'b000;
      hist_b.push_back(sw_in_b);
      mb = model_step(mb, v, 4, 2, u);
      if (u) expq_b.push_back(mb.out);
    end
  end

  // Monitor A: pulses are matched against the queue, levels against the model.
  always @(negedge clk) begin : mon_a
    logic [2:0] e;
    if (!reset) begin
      check({sw_out_a, busy_a, sw_changed_a} == 5'b0, "a_reset_hold",
            {sw_out_a, busy_a, sw_changed_a}, 0);
      prev_chg_a = 1'b0;
    end else begin
      check(sw_out_a == ma.out, "a_sw_out", sw_out_a, ma.out);
      check(busy_a == ma.busy, "a_busy", busy_a, ma.busy);
      if (expq_a.size() == 0) begin
        check(sw_changed_a == 1'b0, "a_no_pulse", sw_changed_a, 0);
      end else begin
        e = expq_a.pop_front();
        check(sw_changed_a && sw_out_a == e, "a_pulse", {sw_changed_a, sw_out_a}, {1'b1, e});
      end
      check(!(sw_changed_a && prev_chg_a), "a_no_double_pulse", prev_chg_a, 0);
      if (sw_changed_a) pulses_a++;
      prev_chg_a = sw_changed_a;
    end
  end

  // Monitor B.
  always @(negedge clk) begin : mon_b
    logic [2:0] e;
    if (!reset) begin
      check({sw_out_b, busy_b, sw_changed_b} == 5'b0, "b_reset_hold",
            {sw_out_b, busy_b, sw_changed_b}, 0);
      prev_chg_b = 1'b0;
    end else begin
      check(sw_out_b == mb.out, "b_sw_out", sw_out_b, mb.out);
      check(busy_b == mb.busy, "b_busy", busy_b, mb.busy);
      if (expq_b.size() == 0) begin
        check(sw_changed_b == 1'b0, "b_no_pulse", sw_changed_b, 0);
      end else begin
        e = expq_b.pop_front();
        check(sw_changed_b && sw_out_b == e, "b_pulse", {sw_changed_b, sw_out_b}, {1'b1, e});
      end
      check(!(sw_changed_b && prev_chg_b), "b_no_double_pulse", prev_chg_b, 0);
      if (sw_changed_b) pulses_b++;
      prev_chg_b = sw_changed_b;
    end
  end

  // Callers are always positioned just after a falling clock edge.
  task automatic hold_a(input logic [2:0] v, input int cyc);
    sw_in_a = v;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic hold_b(input logic [2:0] v, input int cyc);
    sw_in_b = v;
    repeat (cyc) @(negedge clk);
  endtask

  initial begin : stim
    int p0;
    int c;
    logic [2:0] codes [6];
    codes = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110};

    reset   = 1'b0;
    sw_in_a = 3'b000;
    sw_in_b = 3'b000;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Clean step, then back to 000 so the bounce starts from a quiet output.
    hold_a(3'b001, 8);
    hold_a(3'b000, 8);

    // Bounce back after three cycles: no update expected.
    p0 = pulses_a;
    hold_a(3'b100, 3);
    hold_a(3'b000, 8);
    check(pulses_a == p0, "a_bounce_no_pulse", pulses_a - p0, 0);
    check(sw_out_a == 3'b000, "a_bounce_out", sw_out_a, 0);

    // Re-candidate 001 -> 011.
    p0 = pulses_a;
    hold_a(3'b001, 2);
    hold_a(3'b011, 10);
    check(pulses_a - p0 == 1, "a_recand_pulses", pulses_a - p0, 1);
    check(sw_out_a == 3'b011, "a_recand_out", sw_out_a, 3);

    // Reset while qualifying 101.
    sw_in_a = 3'b101;
    c = 0;
    while (!busy_a && c < 20) begin
      @(negedge clk);
      c++;
    end
    check(busy_a == 1'b1, "a_busy_before_reset", busy_a, 1);
    p0 = pulses_a;
    #2 reset = 1'b0;
    #1;
    check({sw_out_a, busy_a, sw_changed_a} == 5'b0, "a_reset_midcheck",
          {sw_out_a, busy_a, sw_changed_a}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    hold_a(3'b101, 10);
    check(pulses_a - p0 == 1, "a_requal_pulses", pulses_a - p0, 1);
    check(sw_out_a == 3'b101, "a_requal_out", sw_out_a, 5);

    // Code sequence, ten cycles per code.
    p0 = pulses_a;
    foreach (codes[i]) hold_a(codes[i], 10);
    check(pulses_a - p0 == 6, "a_sequence_pulses", pulses_a - p0, 6);
    check(sw_out_a == 3'b110, "a_sequence_out", sw_out_a, 6);

    // Randomized switch chatter on the fast instance.
    for (int i = 0; i < 80; i++)
      hold_a(3'($urandom_range(0, 7)), int'($urandom_range(1, 7)));
    hold_a(sw_in_a, 10);

    // Slow tick latency window on instance B.
    sw_in_b = 3'b010;
    c = 0;
    while (sw_out_b != 3'b010 && c < 20) begin
      @(negedge clk);
      c++;
    end
    check(c >= 8 && c <= 11, "b_slow_tick_latency", c, 8);

    for (int i = 0; i < 80; i++)
      hold_b(3'($urandom_range(0, 7)), int'($urandom_range(1, 14)));
    hold_b(sw_in_b, 20);

    @(negedge clk);
    check(expq_a.size() == 0, "a_queue_drained", expq_a.size(), 0);
    check(expq_b.size() == 0, "b_queue_drained", expq_b.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
